// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack responder: FSM encoding, default
// parameter values and the count-width helper.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP_WR = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 8;

  // count must represent 0..DEPTH inclusive, hence one bit above the index.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// LIFO storage: DEPTH x DATA_W register file, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module stack_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_responder.sv
// Push/pop responder with LIFO storage; a pop also writes the word to data RAM.
// Define STACK_ERR_FLAGS_EN to get sticky overflow/underflow flags (else tied 0).
module stack_responder
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_req,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop_req,
  input  logic [ADDR_W-1:0]          pop_addr,
  output logic                       ack,
  output logic [DATA_W-1:0]          tos,
  output logic [count_w(DEPTH)-1:0]  count,
  output logic                       empty,
  output logic                       full,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = count_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  // Handshake: the requester holds *_req (and its data) until it samples
  // ack high, then drops it the following cycle. ack is a single-cycle pulse.
  state_t            state, state_nxt;
  logic [CW-1:0]     count_r;
  logic              do_push, do_pop, mem_we;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign empty = (count_r == '0);
  assign full  = (count_r == CW'(DEPTH));

  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (push_req) begin
          do_push   = 1'b1;
          state_nxt = ACK;
        end else if (pop_req) begin
          do_pop    = 1'b1;
          state_nxt = empty ? ACK : POP_WR;
        end
      end
      POP_WR:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_we = do_push && !full;
  assign wr_idx = AW'(count_r);
  assign rd_idx = AW'(count_r - CW'(1));

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx),
    .wdata (push_data),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  // The RAM word and address are captured at the pop edge so POP_WR can
  // drive them while count already reflects the removal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count_r   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (mem_we) count_r <= count_r + CW'(1);
      if (do_pop && !empty) begin
        count_r   <= count_r - CW'(1);
        ram_addr  <= pop_addr;
        ram_wdata <= rd_word;
      end
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push && full) overflow  <= 1'b1;
      if (do_pop && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign ack    = (state == ACK);
  assign ram_we = (state == POP_WR);
  assign tos    = empty ? '0 : rd_word;
  assign count  = count_r;

endmodule
